// File: rtl/stall_control_unit_if.sv
// Data-memory access handshake between the stall controller (master) and data memory (slave).
// mem_req_i is a level request from the MEM stage. dmem_start_o is a one-cycle start pulse. dmem_ack_i is a one-cycle completion pulse.
interface stall_control_unit_if;
    logic mem_req_i;
    logic dmem_ack_i;
    logic dmem_start_o;

    modport master (
        input  mem_req_i,
        input  dmem_ack_i,
        output dmem_start_o
    );

    modport slave (
        output mem_req_i,
        output dmem_ack_i,
        input  dmem_start_o
    );
endinterface

// File: rtl/stall_control_unit.sv
// Hazard and stall controller: handles load-use bubbles, taken-branch IF flushes and multi-cycle data-memory waits.
// State and counters are registered. Pipeline controls are combinational from state and inputs.
module stall_control_unit #(
    parameter int CNT_W    = 16,
    parameter int WAIT_MAX = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [4:0]           IF_ID_RSaddr_i,
    input  logic [4:0]           IF_ID_RTaddr_i,
    input  logic [4:0]           ID_EX_RTaddr_i,
    input  logic                 ID_EX_MemRead_i,
    input  logic                 branch_taken_i,
    stall_control_unit_if.master dmem,
    output logic                 PC_write_o,
    output logic                 IF_ID_write_o,
    output logic                 ID_EX_bubble_o,
    output logic                 IF_ID_flush_o,
    output logic                 pipe_hold_o,
    output logic [CNT_W-1:0]     stall_cnt_o,
    output logic [CNT_W-1:0]     flush_cnt_o,
    output logic                 mem_err_o,
    output logic [1:0]           dbg_state_o
);
    localparam int WW = $clog2(WAIT_MAX + 2);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WW-1:0]    r_wait_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             r_mem_err;

    logic w_lu;
    logic w_start;
    logic w_pc_write;
    logic w_if_id_write;
    logic w_bubble;
    logic w_flush;
    logic w_hold;

    assign w_lu = ID_EX_MemRead_i && (ID_EX_RTaddr_i != 5'd0) &&
                  ((ID_EX_RTaddr_i == IF_ID_RSaddr_i) || (ID_EX_RTaddr_i == IF_ID_RTaddr_i));

    // In DONE, mem_req_i is ignored because it still reflects the access that has just completed.
    always_comb begin
        w_start       = 1'b0;
        w_pc_write    = 1'b0;
        w_if_id_write = 1'b0;
        w_bubble      = 1'b0;
        w_flush       = 1'b0;
        w_hold        = 1'b0;
        if (rst_i) begin
            case (r_state)
                ST_RUN, ST_DONE: begin
                    if (r_state == ST_RUN && dmem.mem_req_i) begin
                        w_start = 1'b1;
                        w_hold  = 1'b1;
                    end else if (w_lu) begin
                        w_bubble = 1'b1;
                    end else if (branch_taken_i) begin
                        w_flush       = 1'b1;
                        w_pc_write    = 1'b1;
                        w_if_id_write = 1'b1;
                    end else begin
                        w_pc_write    = 1'b1;
                        w_if_id_write = 1'b1;
                    end
                end
                ST_WAIT: w_hold = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state     <= ST_RUN;
            r_wait_cnt  <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
            r_mem_err   <= 1'b0;
        end else begin
            if (!w_pc_write && !(&r_stall_cnt))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (w_flush && !(&r_flush_cnt))
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            case (r_state)
                ST_RUN: begin
                    if (dmem.mem_req_i) begin
                        r_state    <= ST_WAIT;
                        r_wait_cnt <= '0;
                    end
                end
                ST_WAIT: begin
                    // The wait counter stops at WAIT_MAX+1, so the timeout stays flagged without wrapping.
                    if (r_wait_cnt <= WW'(WAIT_MAX))
                        r_wait_cnt <= r_wait_cnt + WW'(1);
                    if (r_wait_cnt == WW'(WAIT_MAX))
                        r_mem_err <= 1'b1;
                    if (dmem.dmem_ack_i)
                        r_state <= ST_DONE;
                end
                ST_DONE: r_state <= ST_RUN;
                default: r_state <= ST_RUN;
            endcase
        end
    end

    assign dmem.dmem_start_o = w_start;
    assign PC_write_o        = w_pc_write;
    assign IF_ID_write_o     = w_if_id_write;
    assign ID_EX_bubble_o    = w_bubble;
    assign IF_ID_flush_o     = w_flush;
    assign pipe_hold_o       = w_hold;
    assign stall_cnt_o       = r_stall_cnt;
    assign flush_cnt_o       = r_flush_cnt;
    assign mem_err_o         = r_mem_err;
    assign dbg_state_o       = r_state;
endmodule
